cmp_issue_ctrl: RTL
===================

// Module: cmp_issue_ctrl
// PURPOSE
//  Initiator/consumer side of the comparator interface. Accepts compare requests
//  (A, B, function) over a valid/ready port and drives one single-cycle cmp_en
//  pulse with operands and function. Captures the registered cmp_out/cmp_flag
//  response, decodes it to a boolean, and returns it on a valid/ready port.
//  Sits between the system control FSM and the ALU compare unit.
// PARAMETERS
//  in_width  16  operand width; must match the compare unit
//  TIMEOUT    8  max cycles to wait for cmp_flag after the pulse; range 2..255
// PORTS
//  clk          in   1         single clock; all logic on posedge
//  rst          in   1         synchronous, active-high reset
//  req_valid    in   1         request present
//  req_ready    out  1         controller can accept a request
//  req_a        in   in_width  operand A
//  req_b        in   in_width  operand B
//  req_fun      in   2         00 NOP, 01 A==B, 10 A>B, 11 A<B
//  cmp_a        out  in_width  operand A to the compare unit
//  cmp_b        out  in_width  operand B to the compare unit
//  Alu_fun_cmp  out  2         function to the compare unit
//  cmp_en       out  1         one-cycle issue pulse
//  cmp_out      in   2         compare unit result code
//  cmp_flag     in   1         compare unit result-valid
//  rsp_valid    out  1         response present
//  rsp_ready    in   1         downstream accepts the response
//  rsp_true     out  1         comparison held
//  rsp_code     out  2         raw captured cmp_out
//  rsp_err      out  1         timeout, or illegal code
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): FSM goes to IDLE. These outputs are 0 on reset:
//   req_ready, cmp_en, cmp_a, cmp_b, Alu_fun_cmp, rsp_*. Timeout counter is cleared.
//   Reset mid-operation drops any in-flight request or response; no response is produced.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE:
//   - req_ready=1 (registered; it is 1 in the cycle after reset ends).
//   - On req_valid&&req_ready, latch a/b/fun into cmp_a/cmp_b/Alu_fun_cmp and go to ISSUE.
//  ISSUE:
//   - cmp_en=1 for exactly this cycle; req_ready=0; cmp_a/cmp_b/Alu_fun_cmp held stable.
//   - Go to WAIT and clear the counter.
//  WAIT:
//   - cmp_en=0. The compare unit answers one cycle after the cmp_en edge, so
//     cmp_flag is expected in the first WAIT cycle.
//   - On cmp_flag=1: capture rsp_code=cmp_out and go to RESP.
//   - Otherwise increment the counter.
//   - If the counter reaches TIMEOUT-1 with no flag: go to RESP with rsp_err=1,
//     rsp_code=00, rsp_true=0.
//  Decode, fixed at capture time:
//   - rsp_true = (fun!=00) && (cmp_out==fun).
//   - rsp_err=1 if cmp_out is not 00 and not equal to fun (illegal code).
//   - NOP (fun=00) gives rsp_true=0, rsp_err=0, provided the flag arrives.
//  RESP:
//   - rsp_valid=1; rsp_* held stable until rsp_ready.
//   - On rsp_valid&&rsp_ready: clear rsp_valid and go to IDLE.
//   - The next request may be accepted no earlier than the cycle after the handshake.
//  Throughput: one compare in flight. Minimum request-to-rsp_valid latency is 3 cycles.
//  A cmp_flag arriving outside WAIT is ignored. Operand outputs hold their last
//  values between requests.
// STRUCTURE
//  Shared package cmp_pkg:
//   - Function codes FUN_NOP, FUN_EQ, FUN_GT, FUN_LT.
//   - State encodings ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP.
//  Both the compare unit and this block take their encodings from cmp_pkg.
//  Single flat module; no sub-module. The timeout counter is inline, $clog2(TIMEOUT) bits.
// TESTING (paired with the real compare unit, in_width=16)
//  1. Request A=5, B=5, fun=01, rsp_ready=1.
//     -> One cmp_en pulse; rsp_valid 3 cycles after accept; rsp_true=1, rsp_code=01, rsp_err=0.
//  2. Request A=9, B=3, fun=10, then A=9, B=3, fun=11, back to back.
//     -> First: rsp_true=1, code=10. Second: rsp_true=0, code=00. Second is accepted only after the first handshake.
//  3. Request fun=11, hold rsp_ready=0 for 5 cycles.
//     -> rsp_* stable, req_ready=0 throughout; one handshake clears rsp_valid.
//  4. Compare unit replaced by a stub that never raises cmp_flag, TIMEOUT=8.
//     -> rsp_err=1, rsp_true=0 after 8 WAIT cycles; FSM returns to IDLE.
//  5. Stub returns cmp_out=10 for fun=01.
//     -> rsp_err=1, rsp_true=0, rsp_code=10.
//  6. Assert rst in the WAIT cycle.
//     -> Next cycle all outputs are 0; no rsp_valid; a new request completes normally.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings for the comparator interface: function codes, controller
// states and the response decode used at capture time.
package cmp_pkg;

  typedef enum logic [1:0] {
    FUN_NOP = 2'b00,
    FUN_EQ  = 2'b01,
    FUN_GT  = 2'b10,
    FUN_LT  = 2'b11
  } cmp_fun_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } cmp_state_e;

  // The compare unit answers with the function code when the relation holds, 00 otherwise.
  function automatic logic cmp_decode_true(input logic [1:0] fun, input logic [1:0] code);
    return (fun != FUN_NOP) && (code == fun);
  endfunction

  function automatic logic cmp_decode_err(input logic [1:0] fun, input logic [1:0] code);
    return (code != FUN_NOP) && (code != fun);
  endfunction

endpackage

// File: rtl/cmp_issue_ctrl.sv
// Comparator initiator: accepts a request, issues one cmp_en pulse, captures
// the flagged result (or times out) and returns a decoded response.
module cmp_issue_ctrl
  import cmp_pkg::*;
#(
  parameter int in_width = 16,
  parameter int TIMEOUT  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [in_width-1:0] req_a,
  input  logic [in_width-1:0] req_b,
  input  logic [1:0]          req_fun,
  output logic [in_width-1:0] cmp_a,
  output logic [in_width-1:0] cmp_b,
  output logic [1:0]          Alu_fun_cmp,
  output logic                cmp_en,
  input  logic [1:0]          cmp_out,
  input  logic                cmp_flag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_true,
  output logic [1:0]          rsp_code,
  output logic                rsp_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  cmp_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                cmp_en_q, cmp_en_d;
  logic [in_width-1:0] cmp_a_q, cmp_a_d;
  logic [in_width-1:0] cmp_b_q, cmp_b_d;
  logic [1:0]          fun_q, fun_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_true_q, rsp_true_d;
  logic [1:0]          rsp_code_q, rsp_code_d;
  logic                rsp_err_q, rsp_err_d;

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    cmp_en_d    = 1'b0;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    fun_d       = fun_q;
    rsp_valid_d = rsp_valid_q;
    rsp_true_d  = rsp_true_q;
    rsp_code_d  = rsp_code_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          cmp_a_d     = req_a;
          cmp_b_d     = req_b;
          fun_d       = req_fun;
          cmp_en_d    = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ST_ISSUE;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        req_ready_d = 1'b0;
        cnt_d       = {CNT_W{1'b0}};
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // A flag in the final WAIT cycle wins over the timeout.
        if (cmp_flag) begin
          rsp_code_d  = cmp_out;
          rsp_true_d  = cmp_decode_true(fun_q, cmp_out);
          rsp_err_d   = cmp_decode_err(fun_q, cmp_out);
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          rsp_code_d  = 2'b00;
          rsp_true_d  = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      req_ready_q <= 1'b0;
      cmp_en_q    <= 1'b0;
      cmp_a_q     <= {in_width{1'b0}};
      cmp_b_q     <= {in_width{1'b0}};
      fun_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_true_q  <= 1'b0;
      rsp_code_q  <= 2'b00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      cmp_en_q    <= cmp_en_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      fun_q       <= fun_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_true_q  <= rsp_true_d;
      rsp_code_q  <= rsp_code_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign cmp_en      = cmp_en_q;
  assign cmp_a       = cmp_a_q;
  assign cmp_b       = cmp_b_q;
  assign Alu_fun_cmp = fun_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_true    = rsp_true_q;
  assign rsp_code    = rsp_code_q;
  assign rsp_err     = rsp_err_q;

endmodule
